// File: rtl/color_pkg.sv
// Shared colour codes and helpers for the colour event path.
// Exports COLOR_W, color_t, COLOR_NONE..COLOR_CLEAR and is_valid_color().
package color_pkg;

    localparam int COLOR_W = 3;

    typedef logic [COLOR_W-1:0] color_t;

    localparam color_t COLOR_NONE  = 3'd0;
    localparam color_t COLOR_RED   = 3'd1;
    localparam color_t COLOR_GREEN = 3'd2;
    localparam color_t COLOR_BLUE  = 3'd3;
    localparam color_t COLOR_CLEAR = 3'd4;

    function automatic logic is_valid_color(input color_t c);
        return (c <= COLOR_CLEAR);
    endfunction

endpackage

// File: rtl/color_run_counter.sv
// Candidate/run tracking for raw colour readings; emits a one-cycle commit.
// Ports: clk, rst (sync, active-low), code_i/valid_i reading strobe,
//   force_i (force NONE), stable_i, commit_o, commit_color_o.
module color_run_counter
    import color_pkg::*;
#(
    parameter int STABLE_COUNT = 3
) (
    input  logic   clk,
    input  logic   rst,
    input  color_t code_i,
    input  logic   valid_i,
    input  logic   force_i,
    input  color_t stable_i,
    output logic   commit_o,
    output color_t commit_color_o
);

    localparam logic [3:0] RUN_MAX = 4'(STABLE_COUNT);

    color_t     cand_q, cand_d;
    logic [3:0] run_q, run_d;
    color_t     code_s;
    logic       same;

    assign code_s = is_valid_color(code_i) ? code_i : COLOR_NONE;
    assign same   = (code_s == cand_q);

    always_comb begin
        cand_d   = cand_q;
        run_d    = run_q;
        commit_o = 1'b0;
        if (valid_i) begin
            if (same) begin
                run_d = (run_q == RUN_MAX) ? run_q : run_q + 4'd1;
            end else begin
                cand_d = code_s;
                run_d  = 4'd1;
            end
            // Commit only on the strobe that brings the run to threshold.
            commit_o = (run_d == RUN_MAX) && (run_q != RUN_MAX || !same)
                       && (cand_d != stable_i);
        end else if (force_i) begin
            cand_d   = COLOR_NONE;
            run_d    = RUN_MAX;
            commit_o = (stable_i != COLOR_NONE);
        end
    end

    assign commit_color_o = cand_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cand_q <= COLOR_NONE;
            run_q  <= 4'd0;
        end else begin
            cand_q <= cand_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/color_event_filter.sv
// Debounced colour-change events with a one-deep skid buffer and sticky overflow.
// Ports: clk, rst (sync, active-low), color_in/color_in_valid, evt_valid/evt_color/evt_ready,
//   stable_color, overflow, ovf_clr. Optional idle timeout under COLOR_TIMEOUT_EN.
module color_event_filter
    import color_pkg::*;
#(
    parameter int STABLE_COUNT   = 3,
    parameter bit EMIT_NONE      = 1'b0,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic   clk,
    input  logic   rst,
    input  color_t color_in,
    input  logic   color_in_valid,
    output logic   evt_valid,
    output color_t evt_color,
    input  logic   evt_ready,
    output color_t stable_color,
    output logic   overflow,
    input  logic   ovf_clr
);

    if (STABLE_COUNT < 1 || STABLE_COUNT > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("color_event_filter: illegal parameter value");
    end

    color_t stable_q, stable_d;
    logic   slot_v_q, slot_v_d;
    color_t slot_c_q, slot_c_d;
    logic   buf_v_q, buf_v_d;
    color_t buf_c_q, buf_c_d;
    logic   ovf_q, ovf_set;
    logic   commit, new_evt, timeout;
    color_t commit_color;

`ifdef COLOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] idle_q;

    // Fires once as the idle count reaches the limit; a strobe that cycle wins.
    assign timeout = !color_in_valid && (idle_q == TLAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            idle_q <= '0;
        end else if (color_in_valid) begin
            idle_q <= '0;
        end else if (idle_q != TMAX) begin
            idle_q <= idle_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    color_run_counter #(
        .STABLE_COUNT (STABLE_COUNT)
    ) u_run (
        .clk            (clk),
        .rst            (rst),
        .code_i         (color_in),
        .valid_i        (color_in_valid),
        .force_i        (timeout),
        .stable_i       (stable_q),
        .commit_o       (commit),
        .commit_color_o (commit_color)
    );

    assign new_evt  = commit && (EMIT_NONE || commit_color != COLOR_NONE);
    assign stable_d = commit ? commit_color : stable_q;

    always_comb begin
        slot_v_d = slot_v_q;
        slot_c_d = slot_c_q;
        buf_v_d  = buf_v_q;
        buf_c_d  = buf_c_q;
        ovf_set  = 1'b0;
        if (!slot_v_q || evt_ready) begin
            if (buf_v_q) begin
                slot_v_d = 1'b1;
                slot_c_d = buf_c_q;
                buf_v_d  = new_evt;
                if (new_evt) buf_c_d = commit_color;
            end else begin
                slot_v_d = new_evt;
                if (new_evt) slot_c_d = commit_color;
            end
        end else if (new_evt) begin
            // Slot stalled: latest event wins the buffer.
            ovf_set = buf_v_q;
            buf_v_d = 1'b1;
            buf_c_d = commit_color;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stable_q <= COLOR_NONE;
            slot_v_q <= 1'b0;
            slot_c_q <= COLOR_NONE;
            buf_v_q  <= 1'b0;
            buf_c_q  <= COLOR_NONE;
            ovf_q    <= 1'b0;
        end else begin
            stable_q <= stable_d;
            slot_v_q <= slot_v_d;
            slot_c_q <= slot_c_d;
            buf_v_q  <= buf_v_d;
            buf_c_q  <= buf_c_d;
            ovf_q    <= ovf_set || (ovf_q && !ovf_clr);
        end
    end

    assign evt_valid    = slot_v_q;
    assign evt_color    = slot_c_q;
    assign stable_color = stable_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_color_event_filter.sv
// Directed bench for color_event_filter: instance A (STABLE_COUNT=3, TIMEOUT 100)
// and instance B (STABLE_COUNT=1) for back-pressure and buffer cases.
module tb_color_event_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic       a_rst = 1'b0, a_valid = 1'b0, a_ready = 1'b1, a_clr = 1'b0;
    logic [2:0] a_color = 3'd0;
    logic       a_evt_valid, a_ovf;
    logic [2:0] a_evt_color, a_stable;

    logic       b_rst = 1'b0, b_valid = 1'b0, b_ready = 1'b0, b_clr = 1'b0;
    logic [2:0] b_color = 3'd0;
    logic       b_evt_valid, b_ovf;
    logic [2:0] b_evt_color, b_stable;

    int a_evt_cnt;

    color_event_filter #(
        .STABLE_COUNT   (3),
        .EMIT_NONE      (1'b0),
        .TIMEOUT_CYCLES (100)
    ) dut_a (
        .clk            (clk),
        .rst            (a_rst),
        .color_in       (a_color),
        .color_in_valid (a_valid),
        .evt_valid      (a_evt_valid),
        .evt_color      (a_evt_color),
        .evt_ready      (a_ready),
        .stable_color   (a_stable),
        .overflow       (a_ovf),
        .ovf_clr        (a_clr)
    );

    color_event_filter #(
        .STABLE_COUNT   (1),
        .EMIT_NONE      (1'b0),
        .TIMEOUT_CYCLES (100)
    ) dut_b (
        .clk            (clk),
        .rst            (b_rst),
        .color_in       (b_color),
        .color_in_valid (b_valid),
        .evt_valid      (b_evt_valid),
        .evt_color      (b_evt_color),
        .evt_ready      (b_ready),
        .stable_color   (b_stable),
        .overflow       (b_ovf),
        .ovf_clr        (b_clr)
    );

    always @(posedge clk) begin
        if (!a_rst) a_evt_cnt <= 0;
        else if (a_evt_valid && a_ready) a_evt_cnt <= a_evt_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic a_strobe(input logic [2:0] c);
        a_color = c;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic b_strobe(input logic [2:0] c);
        b_color = c;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    logic [2:0] seq [6];

    initial begin
        seq[0] = 3'd1; seq[1] = 3'd1; seq[2] = 3'd2;
        seq[3] = 3'd1; seq[4] = 3'd1; seq[5] = 3'd1;
        tick();

        // Reset held with strobes active.
        a_rst = 1'b0; a_valid = 1'b1; a_color = 3'd1;
        tick(); tick();
        chk("rst_evt_valid", a_evt_valid, 0);
        chk("rst_evt_color", a_evt_color, 0);
        chk("rst_stable", a_stable, 0);
        chk("rst_overflow", a_ovf, 0);
        a_rst = 1'b1; a_valid = 1'b0;
        a_strobe(3'd1);
        a_strobe(3'd1);
        chk("rel2_stable", a_stable, 0);
        chk("rel2_evt_valid", a_evt_valid, 0);
        a_strobe(3'd1);
        chk("rel3_evt_valid", a_evt_valid, 1);
        chk("rel3_evt_color", a_evt_color, 1);
        chk("rel3_stable", a_stable, 1);
        tick();
        chk("rel3_drained", a_evt_valid, 0);
        chk("rel3_evt_cnt", a_evt_cnt, 1);

        // Debounce: R,R,G,R,R,R.
        a_rst = 1'b0; tick(); a_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_strobe(seq[i]);
            chk($sformatf("deb_valid_%0d", i), a_evt_valid, (i == 5) ? 1 : 0);
        end
        chk("deb_color", a_evt_color, 1);
        chk("deb_stable", a_stable, 1);
        tick();
        chk("deb_evt_cnt", a_evt_cnt, 1);

        // Invalid code folds to NONE, committed silently.
        a_strobe(3'd6);
        a_strobe(3'd6);
        chk("inv2_stable", a_stable, 1);
        a_strobe(3'd6);
        chk("inv3_stable", a_stable, 0);
        chk("inv3_evt_valid", a_evt_valid, 0);
        tick();
        chk("inv3_evt_cnt", a_evt_cnt, 1);

        // Back-pressure on B: RED, BLUE, GREEN with ready low.
        b_rst = 1'b1; b_ready = 1'b0;
        b_strobe(3'd1);
        chk("bp1_valid", b_evt_valid, 1);
        chk("bp1_color", b_evt_color, 1);
        b_strobe(3'd3);
        chk("bp2_color", b_evt_color, 1);
        chk("bp2_ovf", b_ovf, 0);
        b_strobe(3'd2);
        chk("bp3_color", b_evt_color, 1);
        chk("bp3_ovf", b_ovf, 1);
        chk("bp3_stable", b_stable, 2);
        tick();
        chk("bp_held_color", b_evt_color, 1);
        b_ready = 1'b1;
        tick();
        chk("bp_next_valid", b_evt_valid, 1);
        chk("bp_next_color", b_evt_color, 2);
        tick();
        chk("bp_empty", b_evt_valid, 0);
        chk("bp_ovf_sticky", b_ovf, 1);
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        chk("ovf_cleared", b_ovf, 0);

        // Accept while buffer full and a new commit arrives.
        b_rst = 1'b0; b_ready = 1'b0; tick(); b_rst = 1'b1;
        chk("sim_rst_valid", b_evt_valid, 0);
        b_strobe(3'd1);
        b_strobe(3'd3);
        chk("sim_pre_color", b_evt_color, 1);
        b_ready = 1'b1; b_color = 3'd2; b_valid = 1'b1;
        tick();
        b_valid = 1'b0; b_ready = 1'b0;
        chk("sim_slot_valid", b_evt_valid, 1);
        chk("sim_slot_color", b_evt_color, 3);
        chk("sim_ovf", b_ovf, 0);
        b_ready = 1'b1;
        tick();
        chk("sim_buf_color", b_evt_color, 2);
        chk("sim_buf_valid", b_evt_valid, 1);
        tick();
        chk("sim_empty", b_evt_valid, 0);

        // Idle timeout on A.
        a_strobe(3'd1);
        a_strobe(3'd1);
        a_strobe(3'd1);
        chk("to_red", a_stable, 1);
        repeat (99) tick();
        chk("to_before", a_stable, 1);
        tick();
`ifdef COLOR_TIMEOUT_EN
        chk("to_at_limit", a_stable, 0);
`else
        chk("to_at_limit", a_stable, 1);
`endif
        repeat (50) tick();
`ifdef COLOR_TIMEOUT_EN
        chk("to_after", a_stable, 0);
`else
        chk("to_after", a_stable, 1);
`endif
        chk("to_evt_cnt", a_evt_cnt, 2);
        chk("to_evt_valid", a_evt_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
